sensor_scan_controller: RTL and testbench

SENSOR_SCAN_CONTROLLER -- requirements
Module: sensor_scan_controller

---
 rtl/sensor_scan_controller.sv | 109 ++++++++++
 tb/tb_sensor_scan_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_scan_controller.sv
// Sensor chain scanner: parallel-loads the sensor shift-register chain, clocks
// out 32 bits MSB-first, and debounces the frames into a stable board image.
module sensor_scan_controller #(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_val,
  output logic        sr_clk,
  output logic        parallel_mode,
  output logic [31:0] raw_frame,
  output logic        frame_done,
  output logic [31:0] board_out,
  output logic        board_changed,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_t;

  localparam logic [15:0] PHASE_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]  STABLE_MAX = 4'(STABLE_FRAMES);

  state_t      state;
  state_t      state_next;
  logic [15:0] phase;
  logic [4:0]  bit_idx;
  logic [31:0] shift;
  logic [3:0]  stable;
  logic [3:0]  stable_next;
  logic        phase_end;
  logic        accept;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and the per-state chain control outputs.
  always_comb begin
    state_next    = state;
    sr_clk        = 1'b0;
    parallel_mode = 1'b0;
    frame_done    = 1'b0;
    busy          = (state != IDLE);
    phase_end     = (phase == PHASE_LAST);
    case (state)
      IDLE: if (enable) state_next = LOAD;
      LOAD: begin
        parallel_mode = 1'b1;
        if (phase_end) state_next = LOW;
      end
      LOW:  if (phase_end) state_next = HIGH;
      HIGH: begin
        sr_clk = 1'b1;
        if (phase_end) state_next = (bit_idx == 5'd31) ? DONE : LOW;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = enable ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stability count for the frame just shifted, and whether it is accepted.
  always_comb begin
    stable_next = 4'd1;
    if (shift == raw_frame)
      stable_next = (stable >= STABLE_MAX) ? STABLE_MAX : stable + 4'd1;
    accept = (stable_next >= STABLE_MAX) && (shift != board_out);
  end

  // Phase timing, bit shifting and the frame/board registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      raw_frame     <= '0;
      board_out     <= '0;
      stable        <= '0;
      board_changed <= 1'b0;
    end else begin
      board_changed <= 1'b0;
      if (state == LOAD || state == LOW || state == HIGH)
        phase <= phase_end ? '0 : phase + 16'd1;
      else
        phase <= '0;
      if (state == LOAD && phase_end)
        bit_idx <= '0;
      if (state == HIGH && phase_end && bit_idx != 5'd31)
        bit_idx <= bit_idx + 5'd1;
      if (state == LOW && phase_end)
        shift <= {shift[30:0], in_val};
      if (state == DONE) begin
        raw_frame <= shift;
        stable    <= stable_next;
        if (accept) begin
          board_out     <= shift;
          board_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_scan_controller.sv
// Scoreboard bench: two scanner instances (CLK_DIV=2/STABLE=3 and 1/1), a
// behavioural sensor chain, and a run-length debounce reference model.
module tb_sensor_scan_controller;

  typedef struct {
    logic [31:0] raw;
    logic [31:0] board;
    logic        changed;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  logic enable = 1'b0;
  logic in_val;
  int   sel = 0;
  int   cd = 2;
  int   sf = 3;

  logic        sr0, pm0, fd0, bc0, bz0, sr1, pm1, fd1, bc1, bz1;
  logic [31:0] raw0, bo0, raw1, bo1;
  logic        en0, en1;
  assign en0 = enable && (sel == 0);
  assign en1 = enable && (sel == 1);

  sensor_scan_controller #(.CLK_DIV(2), .STABLE_FRAMES(3)) u0 (
    .clock(clock), .reset(reset), .enable(en0), .in_val(in_val),
    .sr_clk(sr0), .parallel_mode(pm0), .raw_frame(raw0), .frame_done(fd0),
    .board_out(bo0), .board_changed(bc0), .busy(bz0)
  );

  sensor_scan_controller #(.CLK_DIV(1), .STABLE_FRAMES(1)) u1 (
    .clock(clock), .reset(reset), .enable(en1), .in_val(in_val),
    .sr_clk(sr1), .parallel_mode(pm1), .raw_frame(raw1), .frame_done(fd1),
    .board_out(bo1), .board_changed(bc1), .busy(bz1)
  );

  logic        m_sr, m_pm, m_done, m_changed, m_busy;
  logic [31:0] m_raw, m_board;
  assign m_sr      = (sel == 1) ? sr1 : sr0;
  assign m_pm      = (sel == 1) ? pm1 : pm0;
  assign m_done    = (sel == 1) ? fd1 : fd0;
  assign m_changed = (sel == 1) ? bc1 : bc0;
  assign m_busy    = (sel == 1) ? bz1 : bz0;
  assign m_raw     = (sel == 1) ? raw1 : raw0;
  assign m_board   = (sel == 1) ? bo1 : bo0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- sensor chain model ----------------
  logic [31:0] word_q[$];
  logic [31:0] chain = '0;
  logic        chain_loaded = 1'b0;
  logic        sr_q = 1'b0;
  assign in_val = chain[31];

  always @(posedge clock) begin
    sr_q <= m_sr;
    if (reset) begin
      chain_loaded <= 1'b0;
    end else if (m_pm) begin
      if (!chain_loaded) begin
        if (word_q.size() != 0) chain <= word_q.pop_front();
        else                    chain <= '0;
        chain_loaded <= 1'b1;
      end
    end else begin
      chain_loaded <= 1'b0;
      if (m_sr && !sr_q) chain <= chain << 1;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] hist[$];
  logic [31:0] model_board = '0;
  exp_t        exp_q[$];

  task automatic push_frame(input logic [31:0] w);
    int   run;
    exp_t e;
    hist.push_back(w);
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == w; i--) run++;
    e.raw     = w;
    e.changed = (run >= sf) && (w != model_board);
    if (e.changed) model_board = w;
    e.board = model_board;
    exp_q.push_back(e);
    word_q.push_back(w);
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0, pm_before = 0, pm_total = 0, sr_r = 0;
  logic counting = 1'b0, prev_done = 1'b0, prev_pm = 1'b0, prev_sr = 1'b0;
  logic en_at_done = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      counting  = 1'b0;
      prev_done = 1'b0;
      cyc = 0; pm_before = 0; pm_total = 0; sr_r = 0;
    end else begin
      if (prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("raw_frame", m_raw, e.raw);
          chk("board_out", m_board, e.board);
          chk("board_changed", m_changed, e.changed);
        end
        chk("busy_after_done", m_busy, en_at_done);
      end else if (m_changed) begin
        chk("stray_board_changed", m_changed, 1'b0);
      end
      if (m_pm && !prev_pm) begin
        counting = 1'b1;
        cyc = 0; pm_before = 0; pm_total = 0; sr_r = 0;
      end
      if (counting) begin
        cyc++;
        if (m_pm) pm_total++;
        if (m_pm && sr_r == 0) pm_before++;
        if (m_sr && !prev_sr) sr_r++;
      end
      if (m_done) begin
        chk("frame_cycles", cyc, 65 * cd + 1);
        chk("sr_clk_pulses", sr_r, 32);
        chk("pm_before_sr", pm_before, cd);
        chk("pm_total", pm_total, cd);
        counting   = 1'b0;
        en_at_done = enable;
      end
      prev_done = m_done;
    end
    prev_pm = m_pm;
    prev_sr = m_sr;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_raw", m_raw, 32'h0);
    chk("rst_board", m_board, 32'h0);
    chk("rst_flags", {m_done, m_changed, m_busy, m_sr, m_pm}, 5'b0);
    hist.delete();
    model_board = '0;
    exp_q.delete();
    word_q.delete();
  endtask

  task automatic select_dut(input int s);
    sel = s;
    cd  = (s == 1) ? 1 : 2;
    sf  = (s == 1) ? 1 : 3;
    do_reset();
  endtask

  // Runs the queued frames; enable drops during the last frame at drop_bit.
  task automatic run_pending(input int drop_bit);
    int n;
    enable = 1'b1;
    n = 0;
    while (word_q.size() != 0 && n < 20000) begin tick(); n++; end
    chk("words_consumed_timeout", word_q.size() == 0, 1'b1);
    tick();
    n = 0;
    while (sr_r < drop_bit && n < 2000) begin tick(); n++; end
    enable = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < 2000) begin tick(); n++; end
    chk("drain_timeout", (exp_q.size() == 0) && !m_busy, 1'b1);
    repeat (4 * cd + 3) tick();
    chk("stays_idle", m_busy, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    select_dut(0);

    // steady word: accepted on the third identical frame only
    repeat (5) push_frame(32'hA5A50F0F);
    run_pending(0);

    // enable dropped mid-frame at bit 10: frame still completes
    push_frame(32'hA5A50F0F);
    run_pending(10);

    // reset at bit 20 after acceptance, then a clean restart
    word_q.push_back(32'hA5A50F0F);
    enable = 1'b1;
    begin
      int n = 0;
      while (word_q.size() != 0 && n < 2000) begin tick(); n++; end
      tick();
      n = 0;
      while (sr_r < 20 && n < 2000) begin tick(); n++; end
      chk("bit20_timeout", sr_r >= 20, 1'b1);
    end
    do_reset();
    repeat (3) push_frame(32'hA5A50F0F);
    run_pending(0);

    // alternating frames never stabilise
    do_reset();
    for (int i = 0; i < 10; i++) push_frame((i % 2 == 0) ? 32'h1 : 32'h2);
    run_pending(0);

    // random frames with frequent repeats
    w = $urandom;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) w = $urandom;
      push_frame(w);
    end
    run_pending($urandom_range(0, 31));

    // fast instance: every differing frame updates the board
    select_dut(1);
    push_frame(32'hFFFFFFFF);
    push_frame(32'h80000001);
    run_pending(0);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) w = $urandom;
      push_frame(w);
    end
    run_pending(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
